// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared size and state encodings and byte-lane enables for the LSU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } lsu_size_e;

  // State encoding kept as plain constants for legacy tools that dump raw codes
  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE    = 2'd0;
  localparam lsu_state_t ST_ISSUE   = 2'd1;
  localparam lsu_state_t ST_CAPTURE = 2'd2;
  localparam lsu_state_t ST_RESP    = 2'd3;

  localparam logic [3:0] C_BE_BYTE = 4'b0001;
  localparam logic [3:0] C_BE_HALF = 4'b0011;
  localparam logic [3:0] C_BE_WORD = 4'b1111;

  function automatic logic [3:0] be_for_size(input lsu_size_e size);
    case (size)
      SIZE_BYTE: be_for_size = C_BE_BYTE;
      SIZE_HALF: be_for_size = C_BE_HALF;
      SIZE_WORD: be_for_size = C_BE_WORD;
      default:   be_for_size = 4'b0000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_extend.sv
// ============================================================================
// Module   : lsu_extend
// Purpose  : Combinational zero/sign extension of load data by access size.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_data,
  input  lsu_size_e   i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_size)
      SIZE_BYTE: o_data = {{24{~i_unsigned & i_data[7]}}, i_data[7:0]};
      SIZE_HALF: o_data = {{16{~i_unsigned & i_data[15]}}, i_data[15:0]};
      default:   o_data = i_data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : Single-outstanding load/store unit with range/size fault checks.
//            Optional macro LSU_MISALIGN_TRAP_EN faults misaligned half/word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 11
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clk_enable,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_store,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_offset_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  input  logic [31:0] i_mem_rdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_data,
  output logic        o_resp_err
);

  lsu_state_t  r_state;
  lsu_size_e   r_size;
  logic        r_store;
  logic        r_unsigned;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  lsu_size_e   w_req_size;
  logic        w_oob;
  logic        w_misalign;
  logic        w_fault;
  logic [31:0] w_ext;

  assign w_req_size = lsu_size_e'(i_req_size);
  assign w_oob      = |(i_req_addr >> MEM_ADDR_BITS);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((w_req_size == SIZE_HALF) && i_req_addr[0]) ||
                      ((w_req_size == SIZE_WORD) && (i_req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_fault = w_oob || (w_req_size == SIZE_RSVD) || w_misalign;

  lsu_extend u_extend (
    .i_data     (i_mem_rdata),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_size     <= SIZE_BYTE;
      r_store    <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else if (i_clk_enable) begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_size     <= w_req_size;
            r_store    <= i_req_store;
            r_unsigned <= i_req_unsigned;
            r_addr     <= i_req_addr;
            r_wdata    <= i_req_wdata;
            r_rdata    <= '0;
            r_err      <= w_fault;
            r_state    <= w_fault ? ST_RESP : ST_ISSUE;
          end
        end
        ST_ISSUE:   r_state <= r_store ? ST_RESP : ST_CAPTURE;
        ST_CAPTURE: begin
          r_rdata <= w_ext;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (i_resp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready       = (r_state == ST_IDLE);
  assign o_resp_valid      = (r_state == ST_RESP);
  assign o_resp_data       = r_rdata;
  assign o_resp_err        = r_err;
  assign o_mem_addr        = r_addr;
  assign o_mem_offset_addr = r_addr + 32'd4;
  assign o_mem_wdata       = r_wdata;
  assign o_mem_we          = (r_state == ST_ISSUE) && r_store;
  assign o_mem_be          = (r_state == ST_ISSUE) ? be_for_size(r_size) : 4'b0000;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_enable = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] mem_addr;
  logic [31:0] mem_offset_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;

  int total = 0;
  int bad = 0;
  int we_count = 0;

  load_store_unit #(.MEM_ADDR_BITS(11)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_clk_enable      (clk_enable),
    .i_req_valid       (req_valid),
    .o_req_ready       (req_ready),
    .i_req_store       (req_store),
    .i_req_size        (req_size),
    .i_req_unsigned    (req_unsigned),
    .i_req_addr        (req_addr),
    .i_req_wdata       (req_wdata),
    .o_mem_addr        (mem_addr),
    .o_mem_offset_addr (mem_offset_addr),
    .o_mem_wdata       (mem_wdata),
    .o_mem_we          (mem_we),
    .o_mem_be          (mem_be),
    .i_mem_rdata       (mem_rdata),
    .o_resp_valid      (resp_valid),
    .i_resp_ready      (resp_ready),
    .o_resp_data       (resp_data),
    .o_resp_err        (resp_err)
  );

  always #5 clk = ~clk;

  // Count write strobes that the memory would actually commit
  always @(posedge clk) begin
    if (rst_n && clk_enable && mem_we) we_count++;
  end

  // Present a request at a negedge and return at the negedge after the accepting edge
  task automatic accept(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 1000", {req_ready, resp_valid, resp_err, mem_we});
    end
    total++;
    if ({resp_data, mem_addr, mem_wdata, mem_be} !== '0) begin
      bad++; $display("FAIL reset_data: resp_data=%h mem_addr=%h mem_wdata=%h mem_be=%b want 0",
                      resp_data, mem_addr, mem_wdata, mem_be);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_extend();
    logic [1:0]  t_size [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
    logic        t_uns  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] t_addr [6] = '{32'h10, 32'h10, 32'h4, 32'h4, 32'h8, 32'h11};
    logic [31:0] t_rd   [6] = '{32'h000000F0, 32'h000000F0, 32'h00008001,
                                32'h00008001, 32'h80000001, 32'h12345670};
    logic [31:0] t_exp  [6] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8001,
                                32'h00008001, 32'h80000001, 32'h00000070};
    logic [3:0]  t_be   [6] = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b1111, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      int cyc;
      mem_rdata = t_rd[i];
      accept(1'b0, t_size[i], t_uns[i], t_addr[i], 32'h0);
      total++;
      if (mem_be !== t_be[i] || mem_we !== 1'b0 || mem_addr !== t_addr[i]) begin
        bad++; $display("FAIL load_issue[%0d]: be=%b we=%b addr=%h want be=%b we=0 addr=%h",
                        i, mem_be, mem_we, mem_addr, t_be[i], t_addr[i]);
      end
      cyc = 1;
      while (!resp_valid && cyc < 10) begin
        @(negedge clk); cyc++;
      end
      total++;
      if (cyc !== 3 || resp_data !== t_exp[i] || resp_err !== 1'b0) begin
        bad++; $display("FAIL load_resp[%0d]: lat=%0d data=%h err=%b want lat=3 data=%h err=0",
                        i, cyc, resp_data, resp_err, t_exp[i]);
      end
      finish_resp();
      total++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
        bad++; $display("FAIL load_done[%0d]: req_ready=%b resp_valid=%b want 1 0", i, req_ready, resp_valid);
      end
    end
  endtask

  task automatic test_store_word();
    we_count = 0;
    accept(1'b1, 2'd2, 1'b0, 32'h7FC, 32'hDEADBEEF);
    total++;
    if (mem_we !== 1'b1 || mem_be !== 4'b1111 || mem_offset_addr !== 32'h800 ||
        mem_addr !== 32'h7FC || mem_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL store_issue: we=%b be=%b off=%h addr=%h wd=%h want 1 1111 800 7fc deadbeef",
                      mem_we, mem_be, mem_offset_addr, mem_addr, mem_wdata);
    end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h0 || resp_err !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL store_resp: valid=%b data=%h err=%b we=%b want 1 0 0 0",
                      resp_valid, resp_data, resp_err, mem_we);
    end
    finish_resp();
    total++;
    if (we_count !== 1) begin
      bad++; $display("FAIL store_we_count: got %0d want 1", we_count);
    end
  endtask

  task automatic test_fault();
    logic [1:0]  f_size [2] = '{2'd2, 2'd3};
    logic [31:0] f_addr [2] = '{32'h800, 32'h20};
    logic        f_st   [2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      we_count = 0;
      accept(f_st[i], f_size[i], 1'b0, f_addr[i], 32'hFFFFFFFF);
      total++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 32'h0 || mem_we !== 1'b0) begin
        bad++; $display("FAIL fault[%0d]: valid=%b err=%b data=%h we=%b want 1 1 0 0",
                        i, resp_valid, resp_err, resp_data, mem_we);
      end
      finish_resp();
      total++;
      if (we_count !== 0 || req_ready !== 1'b1) begin
        bad++; $display("FAIL fault_we[%0d]: we_count=%0d req_ready=%b want 0 1", i, we_count, req_ready);
      end
    end
  endtask

  task automatic test_misalign();
    mem_rdata = 32'h0000ABCD;
    accept(1'b0, 2'd1, 1'b1, 32'h3, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    total++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin
      bad++; $display("FAIL misalign_trap: valid=%b err=%b want 1 1", resp_valid, resp_err);
    end
`else
    total++;
    if (mem_be !== 4'b0011 || mem_offset_addr !== 32'h7) begin
      bad++; $display("FAIL misalign_issue: be=%b off=%h want 0011 7", mem_be, mem_offset_addr);
    end
    repeat (2) @(negedge clk);
    total++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_data !== 32'h0000ABCD) begin
      bad++; $display("FAIL misalign_resp: valid=%b err=%b data=%h want 1 0 0000abcd",
                      resp_valid, resp_err, resp_data);
    end
`endif
    finish_resp();
  endtask

  task automatic test_clk_enable_hold();
    int unstable = 0;
    we_count = 0;
    accept(1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678);
    clk_enable = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_we !== 1'b1 || mem_be !== 4'b1111 || resp_valid !== 1'b0 ||
          mem_addr !== 32'h100 || mem_wdata !== 32'h12345678) unstable++;
    end
    total++;
    if (unstable !== 0) begin
      bad++; $display("FAIL hold_issue: unstable_cycles=%0d want 0", unstable);
    end
    resp_ready = 1'b0;
    clk_enable = 1'b1;
    @(negedge clk);
    unstable = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== 32'h0 || resp_err !== 1'b0) unstable++;
    end
    clk_enable = 1'b0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    if (resp_valid !== 1'b1) unstable++;
    total++;
    if (unstable !== 0) begin
      bad++; $display("FAIL hold_resp: unstable_cycles=%0d want 0", unstable);
    end
    clk_enable = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    total++;
    if (we_count !== 1 || req_ready !== 1'b1) begin
      bad++; $display("FAIL hold_we_count: we_count=%0d req_ready=%b want 1 1", we_count, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h55;
    @(negedge clk);
    seen[0] = req_ready;
    total++;
    if (mem_be !== 4'b0001 || mem_we !== 1'b1) begin
      bad++; $display("FAIL b2b_issue: be=%b we=%b want 0001 1", mem_be, mem_we);
    end
    @(negedge clk);
    seen[1] = req_ready;
    total++;
    if (resp_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_resp: resp_valid=%b want 1", resp_valid);
    end
    @(negedge clk);
    seen[2] = req_ready;
    @(negedge clk);
    seen[3] = req_ready;
    req_valid = 1'b0;
    total++;
    if (seen !== 4'b0100) begin
      bad++; $display("FAIL b2b_ready_seq: got %b want 0100", seen);
    end
    repeat (2) @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_rdata = 32'hAABBCCDD;
    accept(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, resp_valid, mem_we} !== 3'b100 || mem_be !== 4'b0 ||
        mem_addr !== 32'h0 || resp_data !== 32'h0) begin
      bad++; $display("FAIL reset_mid: ready=%b valid=%b we=%b be=%b addr=%h data=%h want 1 0 0 0 0 0",
                      req_ready, resp_valid, mem_we, mem_be, mem_addr, resp_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    we_count = 0;
    repeat (4) @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || we_count !== 0) begin
      bad++; $display("FAIL reset_release: ready=%b valid=%b we_count=%0d want 1 0 0",
                      req_ready, resp_valid, we_count);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load_extend();
    test_store_word();
    test_fault();
    test_misalign();
    test_clk_enable_hold();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
